// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the IMEM read handshake, a one-entry skid buffer and branch squash.
// Optional IF_PERF_COUNTERS_EN adds IF_FETCH_COUNT / IF_STALL_COUNT outputs.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IF_HOLD,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTRUCTION,
  output logic        IF_VALID,
  output logic        IF_STALL
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0] IF_FETCH_COUNT,
  output logic [31:0] IF_STALL_COUNT
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        skid_valid;

  logic [31:0] pc_seq;
  logic [31:0] target;
  logic        resp_done;
  logic        in_flight;

  assign pc_seq    = pc + 32'd4;
  assign target    = BRANCH_TARGET & ~32'h0000_0003;
  assign resp_done = IMEM_READ & ~IMEM_BUSYWAIT;
  assign in_flight = IMEM_READ & IMEM_BUSYWAIT;
  assign IF_STALL  = in_flight;

  // NOTE: every register here is updated with <=, so all decisions below see pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      IMEM_READ      <= 1'b0;
      IMEM_ADDR      <= RESET_PC;
      IF_PC          <= 32'h0;
      IF_INSTRUCTION <= NOP_INSTR;
      IF_VALID       <= 1'b0;
      skid_pc        <= 32'h0;
      skid_instr     <= NOP_INSTR;
      skid_valid     <= 1'b0;
    end else if (BRANCH_TAKEN) begin
      pc             <= target;
      IF_PC          <= 32'h0;
      IF_INSTRUCTION <= NOP_INSTR;
      IF_VALID       <= 1'b0;
      skid_valid     <= 1'b0;
      IMEM_READ      <= 1'b1;
      if (in_flight) begin
        // Squashed read must finish at its original address before the target is fetched.
        state <= DRAIN;
      end else begin
        state     <= FETCH;
        IMEM_ADDR <= target;
      end
    end else begin
      case (state)
        FETCH: begin
          if (resp_done) begin
            if (!IF_HOLD) begin
              IF_PC          <= pc;
              IF_INSTRUCTION <= IMEM_READDATA;
              IF_VALID       <= 1'b1;
              pc             <= pc_seq;
              IMEM_ADDR      <= pc_seq;
            end else begin
              skid_pc    <= pc;
              skid_instr <= IMEM_READDATA;
              skid_valid <= 1'b1;
              IMEM_READ  <= 1'b0;
              state      <= HOLD;
            end
          end else begin
            // Also the path that issues the first read after reset.
            IMEM_READ <= 1'b1;
            IMEM_ADDR <= pc;
            if (!IF_HOLD) begin
              IF_PC          <= 32'h0;
              IF_INSTRUCTION <= NOP_INSTR;
              IF_VALID       <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (!IF_HOLD) begin
            IF_PC          <= skid_pc;
            IF_INSTRUCTION <= skid_instr;
            IF_VALID       <= skid_valid;
            skid_valid     <= 1'b0;
            pc             <= pc_seq;
            IMEM_READ      <= 1'b1;
            IMEM_ADDR      <= pc_seq;
            state          <= FETCH;
          end
        end
        DRAIN: begin
          if (!IMEM_BUSYWAIT) begin
            IMEM_ADDR <= pc;
            state     <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

`ifdef IF_PERF_COUNTERS_EN
  logic load_valid;

  assign load_valid = ~BRANCH_TAKEN & ~IF_HOLD &
                      (((state == FETCH) & resp_done) | ((state == HOLD) & skid_valid));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      IF_FETCH_COUNT <= 32'h0;
      IF_STALL_COUNT <= 32'h0;
    end else begin
      if (load_valid) IF_FETCH_COUNT <= IF_FETCH_COUNT + 32'd1;
      if (IF_STALL)   IF_STALL_COUNT <= IF_STALL_COUNT + 32'd1;
    end
  end
`endif

endmodule
